vga_addr_gen: RTL

- Pixel-fetch stage directly downstream of the hsync/vsync timing counters.
- Consumes the timing blocks' sync enables and visible-area enables plus the pixel-clock enable pulse.
- Issues frame-buffer read requests for visible pixels and captures the returned data.
- Drives RGB, data-enable and delayed sync outputs, all aligned to a fixed one-pixel pipeline delay.

---
 rtl/vga_addr_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_addr_gen.sv
// Pixel-fetch stage: turns timing-block enables into frame-buffer reads and a
// one-tick-delayed RGB/DE/sync stream. Optional macro: VGA_ADDR_GEN_BORDER_EN.
module vga_addr_gen #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_BIT  = 19,
    parameter int PX_BIT    = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                i_sclr,
    input  logic                i_px_clk,
    input  logic                i_hsync_en,
    input  logic                i_vsync_en,
    input  logic                i_haddr_en,
    input  logic                i_vaddr_en,
    input  logic [PX_BIT-1:0]   i_rdata,
    output logic [ADDR_BIT-1:0] o_raddr,
    output logic                o_ren,
    output logic [PX_BIT-1:0]   o_rgb,
    output logic                o_de,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_frame_done,
    output logic                o_err
);

    localparam int XW = $clog2(H_VISIBLE + 1);
    localparam int YW = $clog2(V_VISIBLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_BIT-1:0]   addr;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  hs_d;
    logic                  vs_d;
    logic                  pend_ovf;
    logic [PX_BIT-1:0]     hold;
    logic                  hold_valid;
    logic [RD_LAT-1:0]     rd_pipe;
`ifdef VGA_ADDR_GEN_BORDER_EN
    logic                  pend_border;
    logic                  border_px;
`endif

    logic                  vis;
    logic                  frame_start;
    state_t                eff_state;
    logic [ADDR_BIT-1:0]   eff_addr;
    logic [XW-1:0]         eff_x;
    logic [YW-1:0]         eff_y;
    logic                  do_fetch;
    logic                  do_ovf;
    logic                  last_px;

    // A frame start on the same tick as a visible pixel overrides the counters,
    // so the fetch on that tick already uses address 0.
    assign vis         = i_haddr_en & i_vaddr_en;
    assign frame_start = i_vsync_en & ~vs_d;
    assign eff_state   = frame_start ? ST_ARMED : state;
    assign eff_addr    = frame_start ? '0 : addr;
    assign eff_x       = frame_start ? '0 : x;
    assign eff_y       = frame_start ? '0 : y;
    assign do_fetch    = i_px_clk & vis & (eff_state == ST_ARMED);
    assign do_ovf      = i_px_clk & vis & (eff_state == ST_DONE);
    assign last_px     = (eff_x == XW'(H_VISIBLE - 1)) && (eff_y == YW'(V_VISIBLE - 1));
`ifdef VGA_ADDR_GEN_BORDER_EN
    assign border_px   = (eff_x == '0) || (eff_x == XW'(H_VISIBLE - 1)) ||
                         (eff_y == '0) || (eff_y == YW'(V_VISIBLE - 1));
`endif

    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            state        <= ST_IDLE;
            addr         <= '0;
            x            <= '0;
            y            <= '0;
            hs_d         <= 1'b0;
            vs_d         <= 1'b0;
            pend_ovf     <= 1'b0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            rd_pipe      <= '0;
`ifdef VGA_ADDR_GEN_BORDER_EN
            pend_border  <= 1'b0;
`endif
            o_raddr      <= '0;
            o_ren        <= 1'b0;
            o_rgb        <= '0;
            o_de         <= 1'b0;
            o_hsync      <= 1'b0;
            o_vsync      <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_ren        <= 1'b0;
            o_frame_done <= 1'b0;
            rd_pipe[0]   <= o_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end

            if (i_px_clk) begin
                hs_d    <= i_hsync_en;
                vs_d    <= i_vsync_en;
                o_hsync <= hs_d;
                o_vsync <= vs_d;

                // Output stage shows whatever the previous tick produced.
                if (pend_ovf) begin
                    o_de  <= 1'b1;
                    o_rgb <= '0;
                end else if (hold_valid) begin
                    o_de  <= 1'b1;
`ifdef VGA_ADDR_GEN_BORDER_EN
                    o_rgb <= pend_border ? '1 : hold;
`else
                    o_rgb <= hold;
`endif
                end else begin
                    o_de  <= 1'b0;
                    o_rgb <= '0;
                end
                hold_valid <= 1'b0;
                pend_ovf   <= do_ovf;
`ifdef VGA_ADDR_GEN_BORDER_EN
                pend_border <= do_fetch & border_px;
`endif

                if (frame_start) begin
                    state <= ST_ARMED;
                    addr  <= '0;
                    x     <= '0;
                    y     <= '0;
                end
                if (do_fetch) begin
                    o_ren   <= 1'b1;
                    o_raddr <= eff_addr;
                    addr    <= eff_addr + ADDR_BIT'(1);
                    if (eff_x == XW'(H_VISIBLE - 1)) begin
                        x <= '0;
                        y <= eff_y + YW'(1);
                    end else begin
                        x <= eff_x + XW'(1);
                    end
                    if (last_px) begin
                        state        <= ST_DONE;
                        o_frame_done <= 1'b1;
                    end
                end
                if (do_ovf) begin
                    o_err <= 1'b1;
                end
            end

            // Returned data lands RD_LAT cycles after the strobe.
            if (rd_pipe[RD_LAT-1]) begin
                hold       <= i_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule
